// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial-bit sequence detector.
// Detects a run-time loaded pattern of 1..MAX_LEN bits, first bit received
// in pat_value[len-1] and last bit in pat_value[0]. Supports overlapping or
// non-overlapping detection, an input-valid qualifier and a registered
// one-cycle match pulse F.
// After reset the detector looks for the legacy sequence 1001.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter on
// match_count. Without it, match_count is tied to 0.
module seq_detect_prog #(
    parameter int  MAX_LEN = 8,
    parameter int  CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               I,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_value,
    input  logic [LEN_W-1:0]   pat_len,
    output logic               F,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0]   ONE_L     = LEN_W'(1);
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(4);
    localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(4'b1001);

    // Architectural state.
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;

    // Next-state values.
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] pat_d;
    logic [LEN_W-1:0]   len_d;
    logic               f_d;

    // Datapath helpers.
    logic [MAX_LEN-1:0] hist_sh;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Mask selecting the low len bits of history and pattern for comparison.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
    end

    // Shift in the new bit and decide whether the updated history completes a match.
    always_comb begin
        hist_sh  = {hist[MAX_LEN-2:0], I};
        fill_inc = (fill == MAX_LEN_L) ? fill : fill + ONE_L;
        match    = (fill_inc >= len) && (((hist_sh ^ pat) & len_mask) == '0);
    end

    // Clamp the requested pattern length into 1..MAX_LEN.
    always_comb begin
        if (pat_len == '0) begin
            len_clamp = ONE_L;
        end else if (pat_len > MAX_LEN_L) begin
            len_clamp = MAX_LEN_L;
        end else begin
            len_clamp = pat_len;
        end
    end

    // Next-state selection: load beats an accepted bit; idle holds everything but F.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        hist_d = hist;
        fill_d = fill;
        pat_d  = pat;
        len_d  = len;
        f_d    = 1'b0;
        if (pat_load) begin
            pat_d  = pat_value;
            len_d  = len_clamp;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_sh;
            f_d    = match;
            fill_d = (match && !overlap) ? '0 : fill_inc;
        end
    end

    // State register with synchronous reset to the legacy 1001 pattern.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            hist <= '0;
            fill <= '0;
            pat  <= RST_PAT;
            len  <= RST_LEN;
            F    <= 1'b0;
        end else begin
            hist <= hist_d;
            fill <= fill_d;
            pat  <= pat_d;
            len  <= len_d;
            F    <= f_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    // Counter next value: cleared by a load, saturating increment on each match.
    always_comb begin
        cnt_d = cnt;
        if (pat_load) begin
            cnt_d = '0;
        end else if (in_valid && match && !(&cnt)) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    // Counter register, updated on the same edge as F.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: a table of per-cycle vectors with
// hand-computed F / match_count, plus a hand-written counter saturation run
// on a second instance built with CNT_W=2.
module tb_seq_detect_prog;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       I;
    logic       overlap;
    logic       pat_load;
    logic [7:0] pat_value;
    logic [3:0] pat_len;
    logic       F;
    logic [7:0] match_count;
    logic       f2;
    logic [1:0] match_count2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .I           (I),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_value   (pat_value),
        .pat_len     (pat_len),
        .F           (F),
        .match_count (match_count)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .I           (I),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_value   (pat_value),
        .pat_len     (pat_len),
        .F           (f2),
        .match_count (match_count2)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic       vld;
        logic       bit_i;
        logic       ovl;
        logic [7:0] pv;
        logic [3:0] pl;
        logic       exp_f;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic load, input logic vld,
                                input logic bit_i, input logic ovl, input logic [7:0] pv,
                                input logic [3:0] pl, input logic exp_f, input int exp_cnt);
        vec_t v;
        v.rst = rst; v.load = load; v.vld = vld; v.bit_i = bit_i; v.ovl = ovl;
        v.pv = pv; v.pl = pl; v.exp_f = exp_f; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endfunction

    // Expected counter value as seen on the port in the current build.
    function automatic int cnt_of(input int n);
`ifdef SEQDET_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic load, input logic vld, input logic bit_i,
                         input logic ovl, input logic [7:0] pv, input logic [3:0] pl);
        @(negedge clock);
        reset = rst; pat_load = load; in_valid = vld; I = bit_i;
        overlap = ovl; pat_value = pv; pat_len = pl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; pat_load = 1'b0; in_valid = 1'b0; I = 1'b0;
        overlap = 1'b1; pat_value = '0; pat_len = '0;

        // Reset with a competing load and valid bit: reset must win.
        add(1, 1, 1, 1, 1, 8'hFF, 4'd1, 0, 0);
        // Legacy 1001, overlapping: 1,0,0,1,0,0,1.
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 0, 1, 2);
        // Same stream, non-overlapping.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 1);
        // Load 110 (len 3) with a valid bit in the load cycle, then 1,1,0,1,1,0.
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 8'b0000_0110, 4'd3, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 1, 1);
        add(0, 0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 1, 2);
        // Default pattern with in_valid toggling; idle I values are decoys.
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 1);
        // Reset mid-match: 1,0,0, reset, 1 -> no F; then 0,0,1 completes a fresh match.
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 1);
        // pat_len=0 behaves as len=1 (pattern "1").
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 8'h01, 4'd0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 0, 1, 2);
        // pat_len=11 behaves as len=8: pattern A5, received MSB first.
        add(0, 1, 0, 0, 1, 8'hA5, 4'd11, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].vld, vecs[i].bit_i,
                  vecs[i].ovl, vecs[i].pv, vecs[i].pl);
            check($sformatf("vec%0d F", i), 32'(F), 32'(vecs[i].exp_f));
            check($sformatf("vec%0d match_count", i), 32'(match_count),
                  32'(cnt_of(vecs[i].exp_cnt)));
        end

        // Saturation on the CNT_W=2 instance: len 1, pattern 1, six valid ones.
        drive(1, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 8'h01, 4'd1);
        check("sat load count", 32'(match_count2), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 1, 1, 1, 0, 0);
            check($sformatf("sat bit%0d F", k), 32'(f2), 32'(1));
            check($sformatf("sat bit%0d count", k), 32'(match_count2),
                  32'(cnt_of((k < 3) ? k : 3)));
        end
        drive(0, 0, 0, 1, 1, 0, 0);
        check("sat idle F", 32'(f2), 32'(0));
        check("sat idle count", 32'(match_count2), 32'(cnt_of(3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
